// File: rtl/counter_8bit_sequencer.sv
// counter_8bit_sequencer
//
// Purpose: drives the enable (E) and mode (M) inputs of an external 8-bit
// up/down counter. An accepted Start request produces exactly Len counter
// advances in the chosen direction, followed by a one-cycle Done pulse.
// Carries/borrows seen from the counter while it is enabled are recorded
// in a sticky Wrap flag.
//
// Optional feature: define SEQ_PAUSE_EN to add the Pause input. Pause freezes
// a run without losing steps. Without the macro the block behaves as if
// Pause were tied low.
//
// Ports:
//   Clk      in   clock, rising edge active
//   Reset    in   asynchronous active-high reset
//   Start    in   run request, only honoured in IDLE
//   Dir      in   run direction (1 = up, 0 = down), latched with Start
//   Len      in   [LEN_W] number of counter steps, latched with Start
//   Abort    in   terminate the current run without a Done pulse
//   Pause    in   (SEQ_PAUSE_EN only) hold the run, freezing remaining steps
//   Cout_in  in   carry/borrow from the driven counter
//   E        out  registered count enable
//   M        out  registered count mode (1 = up, 0 = down)
//   Busy     out  high while a run is in progress
//   Done     out  one-cycle pulse after a run completes normally
//   Wrap     out  sticky carry/borrow seen while E was high

module counter_8bit_sequencer #(
  parameter int LEN_W = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Dir,
  input  logic [LEN_W-1:0] Len,
  input  logic             Abort,
`ifdef SEQ_PAUSE_EN
  input  logic             Pause,
`endif
  input  logic             Cout_in,
  output logic             E,
  output logic             M,
  output logic             Busy,
  output logic             Done,
  output logic             Wrap
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             e_q, e_d;
  logic             m_q, m_d;
  logic             wrap_q, wrap_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic             pauseReq;

`ifdef SEQ_PAUSE_EN
  assign pauseReq = Pause;
`else
  assign pauseReq = 1'b0;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      e_q         <= 1'b0;
      m_q         <= 1'b1;
      wrap_q      <= 1'b0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      e_q         <= e_d;
      m_q         <= m_d;
      wrap_q      <= wrap_d;
      remaining_q <= remaining_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    e_d         = 1'b0;
    m_d         = m_q;
    remaining_d = remaining_q;
    // A carry/borrow only counts when the counter actually advanced.
    wrap_d      = wrap_q | (Cout_in & e_q);

    unique case (state_q)
      IDLE: begin
        // Abort has priority over Start here.
        if (Start && !Abort) begin
          m_d    = Dir;
          wrap_d = 1'b0;
          if (Len != '0) begin
            state_d     = RUN;
            e_d         = 1'b1;
            remaining_d = Len;
          end else begin
            state_d = DONE;
          end
        end
      end

      RUN: begin
        if (Abort) begin
          state_d     = IDLE;
          remaining_d = '0;
        end else if (e_q) begin
          // The step enabled this cycle is consumed at this edge, even if a
          // pause is requested; the final step always completes the run.
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) begin
            state_d = DONE;
          end else begin
            e_d = !pauseReq;
          end
        end else begin
          // Paused: remaining stays frozen until Pause drops.
          e_d = !pauseReq;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign E    = e_q;
  assign M    = m_q;
  assign Busy = (state_q == RUN);
  assign Done = (state_q == DONE);
  assign Wrap = wrap_q;

endmodule

// File: tb/tb_counter_8bit_sequencer.sv
// tb_counter_8bit_sequencer
//
// Self-checking bench for counter_8bit_sequencer. An 8-bit up/down counter
// is modelled around the DUT to supply Cout_in. A reference model plans each
// run as a queue of future per-cycle output slots and is compared against
// the DUT every cycle. Scenario vectors check advance counts, Done pulses,
// final counter value and Wrap. Define SEQ_PAUSE_EN to also exercise Pause.

module tb_counter_8bit_sequencer;

  logic       Clk;
  logic       Reset;
  logic       Start;
  logic       Dir;
  logic [7:0] Len;
  logic       Abort;
`ifdef SEQ_PAUSE_EN
  logic       Pause;
`endif
  logic       Cout_in;
  logic       E;
  logic       M;
  logic       Busy;
  logic       Done;
  logic       Wrap;

  int checks = 0;
  int errors = 0;

  counter_8bit_sequencer #(.LEN_W(8)) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Start   (Start),
    .Dir     (Dir),
    .Len     (Len),
    .Abort   (Abort),
`ifdef SEQ_PAUSE_EN
    .Pause   (Pause),
`endif
    .Cout_in (Cout_in),
    .E       (E),
    .M       (M),
    .Busy    (Busy),
    .Done    (Done),
    .Wrap    (Wrap)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // External 8-bit counter driven by the DUT.
  logic [7:0] cntQ;
  always @(posedge Clk or posedge Reset) begin
    if (Reset) cntQ <= 8'h00;
    else if (E) cntQ <= M ? cntQ + 8'h01 : cntQ - 8'h01;
  end
  assign Cout_in = M ? (cntQ == 8'hFF) : (cntQ == 8'h00);

  // Reference model: a planned sequence of per-cycle output slots.
  typedef struct packed {
    logic e;
    logic busy;
    logic done;
  } slot_t;

  slot_t      plan[$];
  slot_t      cur;
  logic       mM;
  logic       mWrap;
  logic [7:0] mQ;

  function automatic logic pauseIn();
`ifdef SEQ_PAUSE_EN
    return Pause;
`else
    return 1'b0;
`endif
  endfunction

  task automatic modelReset();
    plan.delete();
    cur   = '0;
    mM    = 1'b1;
    mWrap = 1'b0;
    mQ    = 8'h00;
  endtask

  task automatic modelStep();
    if (Reset) begin
      modelReset();
    end else begin
      if (cur.e && (mM ? (mQ == 8'hFF) : (mQ == 8'h00))) mWrap = 1'b1;
      if (cur.e) mQ = mM ? mQ + 8'h01 : mQ - 8'h01;
      if (cur.busy && Abort) begin
        plan.delete();
      end else if (!cur.busy && !cur.done && Start && !Abort) begin
        mM    = Dir;
        mWrap = 1'b0;
        for (int i = 0; i < int'(Len); i++) plan.push_back(slot_t'(3'b110));
        plan.push_back(slot_t'(3'b001));
      end
      if (plan.size() == 0) begin
        cur = '0;
      end else if (pauseIn() && cur.busy && plan[0].busy) begin
        cur = slot_t'(3'b010);
      end else begin
        cur = plan.pop_front();
      end
    end
  endtask

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    checkVal("E", 32'(E), 32'(cur.e));
    checkVal("Busy", 32'(Busy), 32'(cur.busy));
    checkVal("Done", 32'(Done), 32'(cur.done));
    checkVal("M", 32'(M), 32'(mM));
    checkVal("Wrap", 32'(Wrap), 32'(mWrap));
  endtask

  // One clock: model advances on the edge, outputs compared at the negedge.
  task automatic tick();
    @(posedge Clk);
    modelStep();
    @(negedge Clk);
    checkOutput();
  endtask

  task automatic doReset();
    Reset = 1'b1;
    Start = 1'b0;
    Abort = 1'b0;
    modelReset();
    #1;
    checkOutput();
    tick();
    tick();
    Reset = 1'b0;
  endtask

  typedef struct {
    bit         resetFirst;
    bit         dir;
    logic [7:0] len;
    bit         startAbort;
    int         abortAt;
    int         expAdv;
    int         expDone;
    logic [7:0] expQ;
    bit         expWrap;
  } vec_t;

  task automatic applyStimulus(input int idx, input vec_t v);
    int adv;
    int dones;
    bit finished;
    adv = 0;
    dones = 0;
    finished = 1'b0;
    if (v.resetFirst) doReset();
    Start = 1'b1;
    Dir   = v.dir;
    Len   = v.len;
    Abort = v.startAbort;
    tick();
    Abort = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (E) adv++;
      if (Done) dones++;
      if (!Busy && !Done) begin
        finished = 1'b1;
        break;
      end
      // Start, Dir and Len wiggle during the run and must be ignored.
      Start = ($urandom_range(0, 3) == 0);
      Dir   = 1'($urandom);
      Len   = 8'($urandom);
      Abort = (v.abortAt != 0 && E && adv == v.abortAt);
      tick();
    end
    Start = 1'b0;
    Abort = 1'b0;
    checkVal($sformatf("vec%0d finished", idx), 32'(finished), 32'd1);
    checkVal($sformatf("vec%0d advances", idx), 32'(adv), 32'(v.expAdv));
    checkVal($sformatf("vec%0d done pulses", idx), 32'(dones), 32'(v.expDone));
    checkVal($sformatf("vec%0d counter Q", idx), 32'(cntQ), 32'(v.expQ));
    checkVal($sformatf("vec%0d Wrap", idx), 32'(Wrap), 32'(v.expWrap));
  endtask

  vec_t vecs[8];

  initial begin
    int adv;
    int doneAt;
    bit finished;

    Reset = 1'b1;
    Start = 1'b0;
    Dir   = 1'b0;
    Len   = 8'h00;
    Abort = 1'b0;
`ifdef SEQ_PAUSE_EN
    Pause = 1'b0;
`endif
    modelReset();

    //          rst dir len    sAb abortAt adv done Q      wrap
    vecs[0] = '{1, 1, 8'd10,  0,  0,      10,  1,  8'h0A, 0};
    vecs[1] = '{0, 0, 8'd5,   0,  0,      5,   1,  8'h05, 0};
    vecs[2] = '{1, 1, 8'hFF,  0,  0,      255, 1,  8'hFF, 0};
    vecs[3] = '{0, 1, 8'd1,   0,  0,      1,   1,  8'h00, 1};
    vecs[4] = '{1, 1, 8'd20,  0,  4,      4,   0,  8'h04, 0};
    vecs[5] = '{0, 1, 8'd7,   1,  0,      0,   0,  8'h04, 0};
    vecs[6] = '{0, 0, 8'd0,   0,  0,      0,   1,  8'h04, 0};
    vecs[7] = '{1, 0, 8'd3,   0,  0,      3,   1,  8'hFD, 1};

    doReset();
    checkVal("reset M", 32'(M), 32'd1);
    checkVal("reset E", 32'(E), 32'd0);

    for (int i = 0; i < 8; i++) applyStimulus(i, vecs[i]);

    // Reset in the middle of a long run: E drops at once, no Done, and the
    // first edge after Reset deasserts accepts a new Start.
    $display("[TB] reset during run");
    doReset();
    Start = 1'b1;
    Dir   = 1'b1;
    Len   = 8'd50;
    tick();
    Start = 1'b0;
    repeat (5) tick();
    checkVal("midrun E before reset", 32'(E), 32'd1);
    Reset = 1'b1;
    modelReset();
    #1;
    checkVal("midrun E async", 32'(E), 32'd0);
    checkVal("midrun Busy async", 32'(Busy), 32'd0);
    checkOutput();
    tick();
    Reset = 1'b0;
    Start = 1'b1;
    Dir   = 1'b0;
    Len   = 8'd3;
    tick();
    Start = 1'b0;
    checkVal("start after reset Busy", 32'(Busy), 32'd1);
    repeat (5) tick();
    checkVal("after reset run Q", 32'(cntQ), 32'hFD);

`ifdef SEQ_PAUSE_EN
    // Pause held for three sampling edges in the middle of an 8-step run.
    $display("[TB] pause during run");
    doReset();
    Start = 1'b1;
    Dir   = 1'b1;
    Len   = 8'd8;
    tick();
    Start = 1'b0;
    adv = 0;
    doneAt = -1;
    finished = 1'b0;
    for (int c = 1; c < 60; c++) begin
      if (E) adv++;
      if (Done) doneAt = c;
      if (!Busy && !Done) begin
        finished = 1'b1;
        break;
      end
      Pause = (c >= 3 && c <= 5);
      tick();
    end
    Pause = 1'b0;
    checkVal("pause finished", 32'(finished), 32'd1);
    checkVal("pause advances", 32'(adv), 32'd8);
    checkVal("pause done cycle", 32'(doneAt), 32'd12);
    checkVal("pause counter Q", 32'(cntQ), 32'h08);
`endif

    // Randomized traffic compared cycle by cycle with the model.
    $display("[TB] random traffic");
    doReset();
    for (int i = 0; i < 600; i++) begin
      Start = ($urandom_range(0, 3) == 0);
      Dir   = 1'($urandom);
      Len   = 8'($urandom_range(0, 9));
      Abort = ($urandom_range(0, 9) == 0);
`ifdef SEQ_PAUSE_EN
      Pause = ($urandom_range(0, 4) == 0);
`endif
      tick();
      checkVal("random counter Q", 32'(cntQ), 32'(mQ));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_8bit_sequencer.md
COUNTER_8BIT_SEQUENCER -- requirements
Module: counter_8bit_sequencer

Interface
REQ-001 Parameter: LEN_W, default 8, width of the step-count request and internal remaining-steps counter.
REQ-002 Port: Clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: Reset  input  1  asynchronous, active-high reset.
REQ-004 Port: Start  input  1  request a run; sampled only in IDLE.
REQ-005 Port: Dir  input  1  run direction, 1 = up, 0 = down; sampled with accepted Start.
REQ-006 Port: Len  input  LEN_W  number of counter steps for the run; sampled with accepted Start.
REQ-007 Port: Abort  input  1  terminate current run.
REQ-008 Port: Cout_in  input  1  carry/borrow from the driven 8-bit counter.
REQ-009 Port: E  output  1  registered count enable to the counter.
REQ-010 Port: M  output  1  registered mode to the counter, 1 = up, 0 = down.
REQ-011 Port: Busy  output  1  high while state is RUN.
REQ-012 Port: Done  output  1  one-cycle pulse on normal run completion.
REQ-013 Port: Wrap  output  1  sticky, set when Cout_in is high in a cycle where E is high.

Function
REQ-014 FSM states IDLE, RUN, DONE; all outputs registered.
REQ-015 IDLE: E=0; Start=1 and Abort=0 with Len!=0 -> RUN, latch M=Dir and remaining=Len, clear Wrap.
REQ-016 IDLE: Start=1 and Abort=0 with Len==0 -> DONE directly, E never asserted, Wrap cleared.
REQ-017 Start accepted at edge k with Len=N>0 -> E=1 in cycles k+1..k+N, i.e. exactly N counter advances.
REQ-018 RUN: remaining decrements by 1 on each edge where E=1; at the edge where remaining goes 1->0, next state DONE and E=0.
REQ-019 DONE: Done=1 for exactly one cycle, Busy=0, then IDLE.
REQ-020 Start while not in IDLE is ignored; Dir/Len changes during RUN have no effect.
REQ-021 M holds its latched value from Start acceptance until the next accepted Start.
REQ-022 Abort=1 in RUN -> IDLE at the next edge, E=0 from that edge, no Done pulse.
REQ-023 Abort and Start both high in IDLE: Abort wins, Start ignored.
REQ-024 Abort in DONE has no effect; Done still pulses.
REQ-025 Wrap stays set until next accepted Start or Reset.

Reset
REQ-026 Reset=1 asynchronously forces IDLE, E=0, M=1, Busy=0, Done=0, Wrap=0, remaining=0.
REQ-027 Reset asserted mid-RUN aborts the run with no Done; first Start is accepted at the first edge after Reset deasserts.

Configuration
REQ-028 Macro SEQ_PAUSE_EN: when defined, adds input Pause (1 bit); Pause=1 sampled in RUN forces E=0 from the next edge and freezes remaining; Pause=0 resumes E=1 from the next edge; Abort overrides Pause.
REQ-029 Without SEQ_PAUSE_EN: no Pause port; behaviour identical to Pause tied 0.

Verification
REQ-030 Reset, Start=1, Dir=1, Len=10 -> E high exactly 10 cycles, M=1, Done one pulse after, counter Q=0x0A.
REQ-031 From Q=0x0A, Start Dir=0 Len=5 -> E high 5 cycles, M=0, Q=0x05, Done pulse, Wrap=0.
REQ-032 From Q=0x00, Start Dir=1 Len=0xFF then Len=1 -> second run sees Cout_in with E=1, Wrap=1, Q=0x00.
REQ-033 Start Len=20, Abort on 4th E cycle -> exactly 4 advances, Busy drops, no Done; Start+Abort together in IDLE -> stays IDLE.
REQ-034 Start Len=0 -> Done pulse next cycle, E never high; Reset asserted mid-run of Len=50 -> E=0 immediately, no Done.
REQ-035 With SEQ_PAUSE_EN: Len=8, Pause high 3 cycles mid-run -> still exactly 8 advances, Done delayed 3 cycles.
